// File: rtl/bcd_display_pkg.sv
// Shared types and seven-segment patterns for the bcd_display slice.
// Patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package bcd_display_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hundreds;
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd3_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    localparam seg7_t SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bcd_display_seven_seg_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal nibbles and an asserted blank both produce an unlit digit.
module seven_seg_decoder
    import bcd_display_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       blank,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/bcd_display.sv
// Registered 8-bit binary to three-digit seven-segment display driver.
// Optional leading-zero blanking: define BCD_DISPLAY_LEADING_ZERO_BLANK_EN.
module bcd_display
    import bcd_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic [6:0] hex_ones,
    output logic [6:0] hex_tens,
    output logic [6:0] hex_hundreds
);

    // Double dabble, unrolled: adjust each nibble >= 5 by +3, then shift in one bit.
    function automatic bcd3_t bin_to_bcd(input logic [7:0] bin);
        logic [11:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (acc[3:0]  >= 4'd5) acc[3:0]  = acc[3:0]  + 4'd3;
            if (acc[7:4]  >= 4'd5) acc[7:4]  = acc[7:4]  + 4'd3;
            if (acc[11:8] >= 4'd5) acc[11:8] = acc[11:8] + 4'd3;
            acc = {acc[10:0], bin[3'(7 - i)]};
        end
        return acc;
    endfunction

    bcd3_t bcd;
    logic  blank_hundreds;
    logic  blank_tens;
    seg7_t seg_hundreds;
    seg7_t seg_tens;
    seg7_t seg_ones;

    always_comb begin
        bcd = bin_to_bcd(value);
    end

`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    always_comb begin
        blank_hundreds = (bcd.hundreds == 4'd0);
        blank_tens     = blank_hundreds && (bcd.tens == 4'd0);
    end
`else
    always_comb begin
        blank_hundreds = 1'b0;
        blank_tens     = 1'b0;
    end
`endif

    seven_seg_decoder u_dec_hundreds (
        .digit (bcd.hundreds),
        .blank (blank_hundreds),
        .seg   (seg_hundreds)
    );

    seven_seg_decoder u_dec_tens (
        .digit (bcd.tens),
        .blank (blank_tens),
        .seg   (seg_tens)
    );

    seven_seg_decoder u_dec_ones (
        .digit (bcd.ones),
        .blank (1'b0),
        .seg   (seg_ones)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_hundreds <= SEG_BLANK;
            hex_tens     <= SEG_BLANK;
            hex_ones     <= SEG_BLANK;
        end else begin
            hex_hundreds <= seg_hundreds;
            hex_tens     <= seg_tens;
            hex_ones     <= seg_ones;
        end
    end

endmodule

// File: tb/tb_bcd_display.sv
// Self-checking bench for bcd_display: arithmetic reference model, per-cycle compare,
// and literal expectations for the documented examples.
module tb_bcd_display;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic [6:0] hex_ones;
    logic [6:0] hex_tens;
    logic [6:0] hex_hundreds;

    int checks = 0;
    int errors = 0;

    bcd_display dut (
        .clk          (clk),
        .rst          (rst),
        .value        (value),
        .hex_ones     (hex_ones),
        .hex_tens     (hex_tens),
        .hex_hundreds (hex_hundreds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pattern(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Returns {hundreds, tens, ones} segment patterns from plain decimal arithmetic.
    function automatic logic [20:0] model(input logic [7:0] v);
        int h, t, o;
        logic [6:0] sh, st, so;
        h = int'(v) / 100;
        t = (int'(v) / 10) % 10;
        o = int'(v) % 10;
        sh = pattern(h);
        st = pattern(t);
        so = pattern(o);
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
        if (h == 0) sh = 7'h7F;
        if (h == 0 && t == 0) st = 7'h7F;
`endif
        return {sh, st, so};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check3(input string name, input logic [6:0] eh, input logic [6:0] et,
                          input logic [6:0] eo);
        check({name, ".hundreds"}, hex_hundreds, eh);
        check({name, ".tens"}, hex_tens, et);
        check({name, ".ones"}, hex_ones, eo);
    endtask

    // Expected outputs: loaded on each edge from the model, forced blank while rst is high.
    logic [20:0] exp_q;
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= {3{7'h7F}};
        else     exp_q <= model(value);
    end

    always @(negedge clk) begin
        check("cycle", {hex_hundreds, hex_tens, hex_ones} == exp_q ? 7'h00 : 7'h01, 7'h00);
        if ({hex_hundreds, hex_tens, hex_ones} != exp_q)
            $display("  cycle detail: dut %h/%h/%h model %h/%h/%h", hex_hundreds, hex_tens,
                     hex_ones, exp_q[20:14], exp_q[13:7], exp_q[6:0]);
    end

    task automatic apply(input logic [7:0] v);
        value = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        value = 8'd123;
        #1;
        check3("reset_no_clock", 7'h7F, 7'h7F, 7'h7F);
        @(posedge clk);
        #1;
        value = 8'd255;
        #1;
        check3("reset_held", 7'h7F, 7'h7F, 7'h7F);
        rst   = 1'b0;
        value = 8'd0;
        #1;
        check3("after_release_no_edge", 7'h7F, 7'h7F, 7'h7F);
        @(posedge clk);
        #1;

`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
        check3("val0", 7'h7F, 7'h7F, 7'h40);
        apply(8'd17);  check3("val17", 7'h7F, 7'h79, 7'h78);
        apply(8'd105); check3("val105", 7'h79, 7'h40, 7'h12);
        apply(8'd4);   check3("val4", 7'h7F, 7'h7F, 7'h19);
        apply(8'd255); check3("val255", 7'h24, 7'h12, 7'h12);
`else
        check3("val0", 7'h40, 7'h40, 7'h40);
        apply(8'd1);   check3("val1", 7'h40, 7'h40, 7'h79);
        apply(8'd4);   check3("val4", 7'h40, 7'h40, 7'h19);
        apply(8'd17);  check3("val17", 7'h40, 7'h79, 7'h78);
        apply(8'd239); check3("val239", 7'h24, 7'h30, 7'h10);
        apply(8'd255); check3("val255", 7'h24, 7'h12, 7'h12);
        apply(8'd105); check3("val105", 7'h79, 7'h40, 7'h12);
`endif

        // Back-to-back: each result must show exactly one edge after its input.
        value = 8'd0;
        @(posedge clk); #1; value = 8'd1;
        check3("seq0", model(8'd0) >> 14, 7'(model(8'd0) >> 7), 7'(model(8'd0)));
        @(posedge clk); #1; value = 8'd4;
        check3("seq1", model(8'd1) >> 14, 7'(model(8'd1) >> 7), 7'(model(8'd1)));
        @(posedge clk); #1; value = 8'd17;
        check3("seq4", model(8'd4) >> 14, 7'(model(8'd4) >> 7), 7'(model(8'd4)));
        @(posedge clk); #1; value = 8'd239;
        check3("seq17", model(8'd17) >> 14, 7'(model(8'd17) >> 7), 7'(model(8'd17)));
        @(posedge clk); #1;
        check3("seq239", model(8'd239) >> 14, 7'(model(8'd239) >> 7), 7'(model(8'd239)));

        // Hold: constant value keeps outputs constant over several edges.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check3("hold239", model(8'd239) >> 14, 7'(model(8'd239) >> 7), 7'(model(8'd239)));
        end

        // Mid-operation asynchronous reset blanks without a clock edge.
        rst = 1'b1;
        #1;
        check3("async_reset", 7'h7F, 7'h7F, 7'h7F);
        @(posedge clk); #1;
        rst = 1'b0;
        apply(8'd17);
        check3("post_reset17", model(8'd17) >> 14, 7'(model(8'd17) >> 7), 7'(model(8'd17)));

        // Randomized traffic with occasional short asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            value = 8'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
                #3 rst = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        // Exhaustive sweep of every input value.
        for (int v = 0; v < 256; v++) begin
            apply(8'(v));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
